apb_rr_master: RTL and testbench
================================

// Module: apb_rr_master
// PURPOSE
//  Two-port APB master that shares one APB completer (pbslave on apb_if) between
//  two requesters. Round-robin arbitration, APB SETUP/ACCESS sequencing, pready
//  wait states, and a wait-state timeout that reports an error.
//  Sits between on-chip requesters (CPU stub, DMA stub) and the APB bus.
// PARAMETERS
//  ADDR_W       8   paddr / request address width
//  DATA_W       32  pwdata / prdata / request data width
//  TIMEOUT_CYC  16  max ACCESS cycles waiting for pready; 0 = timeout disabled
// PORTS
//  pclk       in   1          bus clock, all logic on rising edge
//  presetn    in   1          asynchronous active-low reset
//  req_valid  in   2          bit i: requester i has a pending transfer
//  req_write  in   2          bit i: 1=write, 0=read
//  req_addr   in   2*ADDR_W   requester i address at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   2*DATA_W   requester i write data at [i*DATA_W +: DATA_W]
//  req_ack    out  2          one-cycle completion pulse to requester i
//  rsp_rdata  out  DATA_W     read data; valid while req_ack!=0
//  rsp_err    out  1          timeout flag; valid while req_ack!=0
//  psel       out  1          APB select
//  penable    out  1          APB enable
//  pwrite     out  1          APB direction
//  paddr      out  ADDR_W     APB address
//  pwdata     out  DATA_W     APB write data
//  prdata     in   DATA_W     APB read data
//  pready     in   1          APB ready
// BEHAVIOUR
//  Reset (async, presetn=0): all outputs 0, state IDLE, last_grant=1 (req 0 wins
//   first), timeout counter 0. Takes effect immediately; no ack is issued for an
//   aborted transfer. After release, the FSM starts in IDLE.
//  All outputs are registered. FSM states:
//   IDLE:   if req_valid!=0, arbitrate. Latch grant g and its write/addr/wdata
//           into pwrite/paddr/pwdata. Set psel=1 and go to SETUP. Otherwise stay.
//   SETUP:  psel=1, penable=0. Next state is ACCESS with penable=1 and counter=0.
//   ACCESS: psel=1, penable=1.
//           - pready=1 sampled: go to DONE. Capture prdata into rsp_rdata (reads
//             only; writes give rsp_rdata=0). rsp_err=0, req_ack[g]=1.
//           - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: go to DONE with
//             rsp_err=1, rsp_rdata=0, req_ack[g]=1.
//           - Else counter++.
//           psel and penable drop to 0 on entry to DONE.
//   DONE:   req_ack[g] high for exactly this cycle. No arbitration. Set
//           last_grant=g and go to IDLE. req_ack, rsp_rdata and rsp_err return to 0.
//  Arbitration: one valid requester is granted. When both are valid, grant
//   !last_grant. last_grant updates only on completion.
//  Requester rule: hold req_valid and fields stable until req_ack. The cycle after
//   ack may present a new request or drop req_valid. A request withdrawn before
//   grant is ignored.
//  pwrite, paddr and pwdata stay constant from SETUP through ACCESS. They hold
//   their last value in IDLE and DONE. pready is ignored outside ACCESS.
//  Latency: request visible in IDLE at cycle 0. SETUP at cycle 1, ACCESS at 2.
//   With a zero-wait slave, ack at cycle 3. Each wait state adds 1 cycle.
//   Back-to-back transfers have a minimum period of 4 cycles.
//  Only one of req_ack[1:0] is ever high at a time.
// TESTING
//  1 Reset: presetn=0 mid-ACCESS -> psel=penable=req_ack=0 immediately. After
//    release, the next transfer starts from IDLE with req 0 priority.
//  2 Single write: req0 write addr 0x10 data 0xA5A5_0001, zero-wait ->
//    SETUP at cycle 1, ACCESS at 2, req_ack=2'b01 at 3, rsp_err=0. Slave
//    readback of 0x10 gives 0xA5A5_0001 on rsp_rdata.
//  3 Round-robin: both valid continuously, 4 transfers each ->
//    grant order 0,1,0,1,... with no requester granted twice in a row.
//  4 Wait states: slave holds pready=0 for 3 cycles on a read ->
//    penable high 4 cycles, paddr/pwrite stable, ack at cycle 6 with prdata.
//  5 Timeout: TIMEOUT_CYC=16, pready stuck 0 -> after 16 ACCESS cycles,
//    req_ack pulses with rsp_err=1 and rsp_rdata=0. The next request proceeds
//    normally.
//  6 Withdraw: req1 pulses valid for 1 cycle while req0 is busy ->
//    no transfer is ever issued for req1.

Source files
------------

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin arbitration onto one APB completer,
// SETUP/ACCESS sequencing, pready wait states and an ACCESS timeout that
// completes the transfer with an error flag. All outputs are registered.
module apb_rr_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ack,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready
);

  // Counter only needs to reach TIMEOUT_CYC-1; a disabled timeout keeps a 1-bit stub.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t             state_q, state_nxt;
  logic               grant_q, grant_nxt;
  logic               last_grant_q, last_grant_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               arb;
  logic [1:0]         req_ack_nxt;
  logic [DATA_W-1:0]  rsp_rdata_nxt;
  logic               rsp_err_nxt;
  logic               psel_nxt;
  logic               penable_nxt;
  logic               pwrite_nxt;
  logic [ADDR_W-1:0]  paddr_nxt;
  logic [DATA_W-1:0]  pwdata_nxt;

  // Next-state and next-output logic; completion outputs default to 0 so they pulse for one cycle.
  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    cnt_nxt        = cnt_q;
    req_ack_nxt    = 2'b00;
    rsp_rdata_nxt  = '0;
    rsp_err_nxt    = 1'b0;
    psel_nxt       = psel;
    penable_nxt    = penable;
    pwrite_nxt     = pwrite;
    paddr_nxt      = paddr;
    pwdata_nxt     = pwdata;
    // A lone requester wins outright; a tie goes to whoever did not complete last.
    arb            = (&req_valid) ? ~last_grant_q : req_valid[1];
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt  = arb;
          pwrite_nxt = req_write[arb];
          paddr_nxt  = arb ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          pwdata_nxt = arb ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_nxt              = 1'b0;
          penable_nxt           = 1'b0;
          rsp_rdata_nxt         = pwrite ? '0 : prdata;
          req_ack_nxt[grant_q]  = 1'b1;
          state_nxt             = DONE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          psel_nxt              = 1'b0;
          penable_nxt           = 1'b0;
          rsp_err_nxt           = 1'b1;
          req_ack_nxt[grant_q]  = 1'b1;
          state_nxt             = DONE;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        last_grant_nxt = grant_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer without acknowledging it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      req_ack      <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      state_q      <= state_nxt;
      grant_q      <= grant_nxt;
      last_grant_q <= last_grant_nxt;
      cnt_q        <= cnt_nxt;
      req_ack      <= req_ack_nxt;
      rsp_rdata    <= rsp_rdata_nxt;
      rsp_err      <= rsp_err_nxt;
      psel         <= psel_nxt;
      penable      <= penable_nxt;
      pwrite       <= pwrite_nxt;
      paddr        <= paddr_nxt;
      pwdata       <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: behavioural APB completer with programmable wait
// states, transaction-level reference model (memory image, round-robin owner).
module tb_apb_rr_master;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                pclk = 1'b0;
  logic                presetn;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ack;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  // Completer: memory, wait states counted per ACCESS phase, random pready outside ACCESS.
  logic [DATA_W-1:0] slv_mem [256];
  logic              slv_clr;
  logic              noise;
  int                wait_cfg = 0;
  int                wcnt = 0;

  function automatic logic [DATA_W-1:0] pat(input int j);
    return DATA_W'(32'h5A00_0000 ^ (j * 32'h0001_0101));
  endfunction

  assign pready = (psel && penable) ? (wcnt >= wait_cfg) : noise;
  assign prdata = slv_mem[paddr];

  always @(negedge pclk) noise <= 1'($urandom_range(0, 1));

  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (slv_clr) begin
      for (int j = 0; j < 256; j++) slv_mem[j] <= pat(j);
    end else if (psel && penable && pready && pwrite) begin
      slv_mem[paddr] <= pwdata;
    end
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [256];
  int                last_g;
  logic              pend_w [2];
  logic [ADDR_W-1:0] pend_a [2];
  logic [DATA_W-1:0] pend_d [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    pend_w[i] = w; pend_a[i] = a; pend_d[i] = d;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    if (i == 0) begin
      req_addr[ADDR_W-1:0]  = a;
      req_wdata[DATA_W-1:0] = d;
    end else begin
      req_addr[2*ADDR_W-1:ADDR_W]  = a;
      req_wdata[2*DATA_W-1:DATA_W] = d;
    end
  endtask

  task automatic new_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
  endtask

  // Waits (bounded) for an ack; tracks phase order and bus-field stability while psel is high.
  task automatic wait_ack(input int base, output int lat, output int pen, output logic [1:0] ack,
                          output logic [DATA_W-1:0] rd, output logic err, output logic ok);
    logic [ADDR_W-1:0] a0;
    logic              w0;
    logic [DATA_W-1:0] d0;
    logic              seen;
    lat = 0; pen = 0; ack = 2'b00; rd = '0; err = 1'b0; ok = 1'b1;
    seen = 1'b0; a0 = '0; w0 = 1'b0; d0 = '0;
    while (lat < 60) begin
      @(negedge pclk);
      lat++;
      if (req_ack != 2'b00) begin
        ack = req_ack; rd = rsp_rdata; err = rsp_err;
        return;
      end
      if (lat == base + 1 && !(psel && !penable)) ok = 1'b0;
      if (lat == base + 2 && !(psel && penable))  ok = 1'b0;
      if (penable) pen++;
      if (psel) begin
        if (!seen) begin
          seen = 1'b1; a0 = paddr; w0 = pwrite; d0 = pwdata;
        end else if (paddr !== a0 || pwrite !== w0 || pwdata !== d0) begin
          ok = 1'b0;
        end
      end
    end
  endtask

  // One isolated transfer from requester i with 'waits' completer wait states.
  task automatic single(input int i, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int waits, output logic [DATA_W-1:0] rd);
    int         lat, pen;
    logic [1:0] ack;
    logic       err, ok, exp_err;
    logic [DATA_W-1:0] exp_rd;
    exp_err  = (waits >= TIMEOUT_CYC);
    exp_rd   = (w || exp_err) ? '0 : ref_mem[a];
    wait_cfg = waits;
    set_req(i, w, a, d);
    wait_ack(0, lat, pen, ack, rd, err, ok);
    check("latency", 64'(lat), 64'(3 + (exp_err ? TIMEOUT_CYC - 1 : waits)));
    check("penable_cycles", 64'(pen), 64'(exp_err ? TIMEOUT_CYC : waits + 1));
    check("ack", 64'(ack), 64'(2'b01 << i));
    check("rdata", 64'(rd), 64'(exp_rd));
    check("err", 64'(err), 64'(exp_err));
    check("phase_and_stable", 64'(ok), 64'(1));
    check("hold_fields", 64'({pwrite, paddr}), 64'({w, a}));
    if (w && !exp_err) ref_mem[a] = d;
    last_g = i;
    req_valid[i] = 1'b0;
    @(negedge pclk);
    check("ack_clear", 64'({req_ack, rsp_err, psel, penable}), 64'(0));
    check("rdata_clear", 64'(rsp_rdata), 64'(0));
  endtask

  // Both requesters kept valid; each completed one immediately re-requests.
  task automatic rr(input int n);
    int         lat, pen, g, base, waits;
    logic [1:0] ack;
    logic [DATA_W-1:0] rd;
    logic       err, ok;
    new_req(0);
    new_req(1);
    wait_cfg = $urandom_range(0, 2);
    base = 0;
    for (int k = 0; k < n; k++) begin
      waits = wait_cfg;
      wait_ack(base, lat, pen, ack, rd, err, ok);
      g = 1 - last_g;
      check("rr_grant", 64'(ack), 64'(2'b01 << g));
      check("rr_latency", 64'(lat), 64'(base + 3 + waits));
      check("rr_rdata", 64'(rd), 64'(pend_w[g] ? '0 : ref_mem[pend_a[g]]));
      check("rr_err", 64'(err), 64'(0));
      check("rr_phase", 64'(ok), 64'(1));
      if (pend_w[g]) ref_mem[pend_a[g]] = pend_d[g];
      last_g = g;
      wait_cfg = $urandom_range(0, 2);
      new_req(g);
      base = 1;
    end
    req_valid = 2'b00;
    @(negedge pclk);
  endtask

  // Requester 1 pulses valid for one cycle while requester 0 is mid-transfer.
  task automatic withdraw();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd0, exp_rd;
    int acks0, acks1, psel_after, ack_cyc;
    a = ADDR_W'($urandom_range(0, 255));
    exp_rd = ref_mem[a];
    acks0 = 0; acks1 = 0; psel_after = 0; ack_cyc = 0; rd0 = '0;
    wait_cfg = 3;
    set_req(0, 1'b0, a, '0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk);
      if (req_ack[1]) acks1++;
      if (req_ack[0]) begin
        acks0++; ack_cyc = c; rd0 = rsp_rdata; req_valid[0] = 1'b0;
      end else if (acks0 != 0 && psel) begin
        psel_after++;
      end
      if (c == 2) set_req(1, 1'b1, 8'h55, 32'hDEAD_BEEF);
      if (c == 3) req_valid[1] = 1'b0;
    end
    last_g = 0;
    check("wd_ack0", 64'(acks0), 64'(1));
    check("wd_ack_cycle", 64'(ack_cyc), 64'(6));
    check("wd_rdata", 64'(rd0), 64'(exp_rd));
    check("wd_no_ack1", 64'(acks1), 64'(0));
    check("wd_no_transfer", 64'(psel_after), 64'(0));
  endtask

  // Reset asserted in the middle of an ACCESS phase.
  task automatic reset_mid();
    logic [DATA_W-1:0] rd;
    single(0, 1'b1, 8'h20, DATA_W'($urandom), 0, rd);
    wait_cfg = 1000;
    set_req(0, 1'b0, 8'h21, '0);
    repeat (4) @(negedge pclk);
    check("pre_reset_access", 64'({psel, penable}), 64'(2'b11));
    presetn = 1'b0;
    #1;
    check("rst_async", 64'({psel, penable, req_ack}), 64'(0));
    req_valid = 2'b00;
    repeat (2) @(negedge pclk);
    check("rst_hold", 64'({req_ack, rsp_err, psel, penable, pwrite, paddr}), 64'(0));
    check("rst_hold_data", 64'({rsp_rdata, pwdata}), 64'(0));
    presetn = 1'b1;
    last_g = 1;
    wait_cfg = 0;
    rr(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    presetn = 1'b0; slv_clr = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    last_g = 1;
    for (int j = 0; j < 256; j++) ref_mem[j] = pat(j);
    repeat (3) @(negedge pclk);
    check("reset_ctrl", 64'({req_ack, rsp_err, psel, penable, pwrite}), 64'(0));
    check("reset_data", 64'({rsp_rdata, paddr}), 64'(0));
    check("reset_wdata", 64'(pwdata), 64'(0));
    slv_clr = 1'b0;
    presetn = 1'b1;
    @(negedge pclk);

    single(0, 1'b1, 8'h10, 32'hA5A5_0001, 0, rd);
    single(0, 1'b0, 8'h10, '0, 0, rd);
    check("readback_0x10", 64'(rd), 64'(32'hA5A5_0001));

    single(1, 1'b0, 8'h10, '0, 3, rd);

    single(0, 1'b0, 8'h33, '0, TIMEOUT_CYC, rd);
    single(1, 1'b1, 8'h34, 32'h1234_5678, TIMEOUT_CYC, rd);
    single(1, 1'b0, 8'h34, '0, 0, rd);
    single(0, 1'b0, 8'h35, '0, TIMEOUT_CYC - 1, rd);

    rr(8);

    withdraw();

    for (int k = 0; k < 10; k++) begin
      single($urandom_range(0, 1), 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
             DATA_W'($urandom), $urandom_range(0, 4), rd);
    end

    rr(6);

    reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
